// File: rtl/regfile_sb_pkg.sv
// Shared constants for the regfile_sb register file and scoreboard.
// Optional forwarding is enabled with the REGFILE_SB_BYPASS_EN macro (see regfile_sb.sv).
package regfile_sb_pkg;

    // Default data and address widths.
    localparam int unsigned DW_DEFAULT = 32;
    localparam int unsigned AW_DEFAULT = 5;

    // Register 0 is hardwired to zero.
    localparam int unsigned REG_ZERO = 0;

    // Number of registers, which is also the busy-vector width.
    function automatic int unsigned busy_width(input int unsigned aw);
        return 32'd1 << aw;
    endfunction

    localparam int unsigned BUSY_W_DEFAULT = busy_width(AW_DEFAULT);

endpackage

// File: rtl/regfile_2r1w.sv
// Two-read / one-write register storage with combinational reads.
// Register 0 is never written and always reads as zero.
module regfile_2r1w
    import regfile_sb_pkg::*;
#(
    parameter int unsigned DW = DW_DEFAULT,
    parameter int unsigned AW = AW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    output logic [DW-1:0] rd1,
    output logic [DW-1:0] rd2
);

    localparam int unsigned NREG = busy_width(AW);

    logic [DW-1:0] mem [NREG];

    // Storage array: cleared on reset, written at the edge unless targeting register 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREG); i++) begin
                mem[i] <= '0;
            end
        end else if (we && (wa != AW'(REG_ZERO))) begin
            mem[wa] <= wd;
        end
    end

    // Combinational reads with the zero register forced to 0.
    always_comb begin
        rd1 = (ra1 == AW'(REG_ZERO)) ? '0 : mem[ra1];
        rd2 = (ra2 == AW'(REG_ZERO)) ? '0 : mem[ra2];
    end

endmodule

// File: rtl/regfile_sb.sv
// Register file with per-register busy scoreboard for the pipelined CPU.
// Issue marks a destination busy and stalls on RAW/WAW hazards; write-back
// commits data and clears busy. Define REGFILE_SB_BYPASS_EN to forward the
// write-back data to the read ports and to let hazards clear in the same cycle.
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int unsigned DW = DW_DEFAULT,
    parameter int unsigned AW = AW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    output logic [DW-1:0] rd1,
    output logic [DW-1:0] rd2,
    input  logic          iss_valid,
    input  logic          iss_use1,
    input  logic          iss_use2,
    input  logic          iss_wr,
    input  logic [AW-1:0] iss_wa,
    output logic          iss_ready,
    input  logic          wb_valid,
    input  logic [AW-1:0] wb_wa,
    input  logic [DW-1:0] wb_wd,
    output logic [AW:0]   pend_cnt,
    output logic          wb_err
);

    localparam int unsigned NREG = busy_width(AW);
    localparam logic [AW:0] CNT_MAX = (AW+1)'(NREG - 1);

    logic [NREG-1:0] busy_q, busy_d, busy_eff;
    logic [AW:0]     pend_cnt_q, pend_cnt_d;
    logic            wb_err_q, wb_err_d;
    logic [DW-1:0]   rf_rd1, rf_rd2;
    logic            set_en, clr_en, inc, dec;

    regfile_2r1w #(
        .DW (DW),
        .AW (AW)
    ) u_rf (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wb_valid),
        .wa    (wb_wa),
        .wd    (wb_wd),
        .ra1   (ra1),
        .ra2   (ra2),
        .rd1   (rf_rd1),
        .rd2   (rf_rd2)
    );

    // Read ports, optionally forwarding the in-flight write-back.
    always_comb begin
        rd1 = rf_rd1;
        rd2 = rf_rd2;
`ifdef REGFILE_SB_BYPASS_EN
        if (wb_valid && (wb_wa != AW'(REG_ZERO)) && (wb_wa == ra1)) begin
            rd1 = wb_wd;
        end
        if (wb_valid && (wb_wa != AW'(REG_ZERO)) && (wb_wa == ra2)) begin
            rd2 = wb_wd;
        end
`endif
    end

    // Hazard check against the effective busy vector.
    always_comb begin
        busy_eff = busy_q;
`ifdef REGFILE_SB_BYPASS_EN
        // A register being written back this cycle no longer blocks.
        if (wb_valid) begin
            busy_eff[wb_wa] = 1'b0;
        end
`endif
        iss_ready = !(iss_use1 && busy_eff[ra1]) &&
                    !(iss_use2 && busy_eff[ra2]) &&
                    !(iss_wr && busy_eff[iss_wa]);
    end

    // Scoreboard next state: clear on write-back, set on issue (set wins), count tracking.
    always_comb begin
        set_en = iss_valid && iss_ready && iss_wr && (iss_wa != AW'(REG_ZERO));
        clr_en = wb_valid && (wb_wa != AW'(REG_ZERO));

        busy_d = busy_q;
        if (clr_en) begin
            busy_d[wb_wa] = 1'b0;
        end
        if (set_en) begin
            busy_d[iss_wa] = 1'b1;
        end
        busy_d[REG_ZERO] = 1'b0;

        inc = set_en && !busy_q[iss_wa];
        // A clear that is overridden by a same-register set leaves the count alone.
        dec = clr_en && busy_q[wb_wa] && !(set_en && (iss_wa == wb_wa));

        pend_cnt_d = pend_cnt_q;
        if (inc && !dec && (pend_cnt_q != CNT_MAX)) begin
            pend_cnt_d = pend_cnt_q + 1'b1;
        end else if (dec && !inc && (pend_cnt_q != '0)) begin
            pend_cnt_d = pend_cnt_q - 1'b1;
        end

        wb_err_d = wb_err_q || (clr_en && !busy_q[wb_wa]);
    end

    // Scoreboard state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q     <= '0;
            pend_cnt_q <= '0;
            wb_err_q   <= 1'b0;
        end else begin
            busy_q     <= busy_d;
            pend_cnt_q <= pend_cnt_d;
            wb_err_q   <= wb_err_d;
        end
    end

    assign pend_cnt = pend_cnt_q;
    assign wb_err   = wb_err_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed vector table plus hand-written
// sequences for reset, full scoreboard and asynchronous mid-cycle reset.
module tb_regfile_sb;

`ifdef REGFILE_SB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  ra1 = '0, ra2 = '0, iss_wa = '0, wb_wa = '0;
    logic [31:0] rd1, rd2, wb_wd = '0;
    logic        iss_valid = 1'b0, iss_use1 = 1'b0, iss_use2 = 1'b0, iss_wr = 1'b0;
    logic        iss_ready, wb_valid = 1'b0, wb_err;
    logic [5:0]  pend_cnt;

    int checks = 0;
    int errors = 0;

    regfile_sb dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ra1       (ra1),
        .ra2       (ra2),
        .rd1       (rd1),
        .rd2       (rd2),
        .iss_valid (iss_valid),
        .iss_use1  (iss_use1),
        .iss_use2  (iss_use2),
        .iss_wr    (iss_wr),
        .iss_wa    (iss_wa),
        .iss_ready (iss_ready),
        .wb_valid  (wb_valid),
        .wb_wa     (wb_wa),
        .wb_wd     (wb_wd),
        .pend_cnt  (pend_cnt),
        .wb_err    (wb_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  ra1, ra2;
        logic        iv, u1, u2, wr;
        logic [4:0]  wa;
        logic        wbv;
        logic [4:0]  wbwa;
        logic [31:0] wd;
        logic        e_rdy;
        logic [31:0] e_rd1, e_rd2;
        logic [5:0]  e_pend;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add(input logic [4:0] a1, input logic [4:0] a2, input logic iv,
                       input logic u1, input logic u2, input logic wr, input logic [4:0] wa,
                       input logic wbv, input logic [4:0] wbwa, input logic [31:0] wd,
                       input logic e_rdy, input logic [31:0] e_rd1, input logic [31:0] e_rd2,
                       input logic [5:0] e_pend, input logic e_err);
        vec_t v;
        v.ra1 = a1; v.ra2 = a2; v.iv = iv; v.u1 = u1; v.u2 = u2; v.wr = wr; v.wa = wa;
        v.wbv = wbv; v.wbwa = wbwa; v.wd = wd; v.e_rdy = e_rdy; v.e_rd1 = e_rd1;
        v.e_rd2 = e_rd2; v.e_pend = e_pend; v.e_err = e_err;
        vecs.push_back(v);
    endtask

    task automatic idle();
        iss_valid = 1'b0; iss_use1 = 1'b0; iss_use2 = 1'b0; iss_wr = 1'b0; iss_wa = '0;
        wb_valid = 1'b0; wb_wa = '0; wb_wd = '0;
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Vector table: inputs applied mid-cycle, outputs checked before the edge.
        add(0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 32'h0, 32'h0, 0, 0);
        add(0, 0, 1, 0, 0, 1, 8, 0, 0, 32'h0, 1, 32'h0, 32'h0, 0, 0);
        add(8, 0, 1, 1, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 1, 0);
        add(8, 0, 0, 1, 0, 0, 0, 1, 8, 32'h12345678, BYP,
            BYP ? 32'h12345678 : 32'h0, 32'h0, 1, 0);
        add(8, 0, 1, 1, 0, 0, 0, 0, 0, 32'h0, 1, 32'h12345678, 32'h0, 0, 0);
        add(0, 0, 1, 0, 0, 1, 0, 0, 0, 32'h0, 1, 32'h0, 32'h0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 1, 0, 32'hFFFFFFFF, 1, 32'h0, 32'h0, 0, 0);
        add(0, 0, 1, 1, 1, 1, 0, 0, 0, 32'h0, 1, 32'h0, 32'h0, 0, 0);
        add(5, 0, 0, 0, 0, 0, 0, 1, 5, 32'h55, 1, BYP ? 32'h55 : 32'h0, 32'h0, 0, 0);
        add(5, 8, 0, 0, 0, 0, 0, 1, 8, 32'h99, 1, 32'h55,
            BYP ? 32'h99 : 32'h12345678, 0, 1);
        add(8, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 32'h99, 32'h0, 0, 1);
        add(0, 0, 1, 0, 0, 1, 3, 0, 0, 32'h0, 1, 32'h0, 32'h0, 0, 1);
        add(3, 3, 1, 0, 0, 1, 3, 1, 3, 32'hAA, BYP, BYP ? 32'hAA : 32'h0,
            BYP ? 32'hAA : 32'h0, 1, 1);
        add(3, 0, 1, 1, 0, 0, 0, 0, 0, 32'h0, !BYP, 32'hAA, 32'h0, BYP ? 6'd1 : 6'd0, 1);
        add(3, 0, 0, 0, 0, 0, 0, 1, 3, 32'hBB, 1, BYP ? 32'hBB : 32'hAA, 32'h0,
            BYP ? 6'd1 : 6'd0, 1);
        add(3, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 32'hBB, 32'h0, 0, 1);

        // Reset state: every address reads zero, no pending, ready.
        idle();
        #12 rst_n = 1'b1;
        tick();
        for (int a = 0; a < 32; a += 2) begin
            ra1 = 5'(a); ra2 = 5'(a + 1);
            #1;
            chk($sformatf("reset_rd1[%0d]", a), rd1, 32'h0);
            chk($sformatf("reset_rd2[%0d]", a + 1), rd2, 32'h0);
        end
        chk("reset_pend", 32'(pend_cnt), 32'd0);
        chk("reset_ready", 32'(iss_ready), 32'd1);
        chk("reset_err", 32'(wb_err), 32'd0);
        tick();

        // Directed vector table.
        foreach (vecs[i]) begin
            ra1 = vecs[i].ra1; ra2 = vecs[i].ra2;
            iss_valid = vecs[i].iv; iss_use1 = vecs[i].u1; iss_use2 = vecs[i].u2;
            iss_wr = vecs[i].wr; iss_wa = vecs[i].wa;
            wb_valid = vecs[i].wbv; wb_wa = vecs[i].wbwa; wb_wd = vecs[i].wd;
            #1;
            chk($sformatf("v%0d_ready", i), 32'(iss_ready), 32'(vecs[i].e_rdy));
            chk($sformatf("v%0d_rd1", i), rd1, vecs[i].e_rd1);
            chk($sformatf("v%0d_rd2", i), rd2, vecs[i].e_rd2);
            chk($sformatf("v%0d_pend", i), 32'(pend_cnt), 32'(vecs[i].e_pend));
            chk($sformatf("v%0d_err", i), 32'(wb_err), 32'(vecs[i].e_err));
            tick();
        end
        idle();

        // Fill every non-zero register with a pending write.
        for (int r = 1; r < 32; r++) begin
            iss_valid = 1'b1; iss_wr = 1'b1; iss_wa = 5'(r);
            #1;
            chk($sformatf("fill_ready[%0d]", r), 32'(iss_ready), 32'd1);
            tick();
        end
        idle();
        ra1 = 5'd17; iss_use1 = 1'b1; ra2 = 5'd8;
        #1;
        chk("full_pend", 32'(pend_cnt), 32'd31);
        chk("full_raw_stall", 32'(iss_ready), 32'd0);

        // Asynchronous reset between edges.
        #1 rst_n = 1'b0;
        #1;
        chk("async_pend", 32'(pend_cnt), 32'd0);
        chk("async_ready", 32'(iss_ready), 32'd1);
        chk("async_err", 32'(wb_err), 32'd0);
        chk("async_rd2", rd2, 32'h0);
        #1 rst_n = 1'b1;
        idle();
        tick();

        // Write-back after reset: data lands and the error flag sets.
        wb_valid = 1'b1; wb_wa = 5'd7; wb_wd = 32'hCAFE0007;
        tick();
        idle();
        ra1 = 5'd7;
        #1;
        chk("post_reset_rd", rd1, 32'hCAFE0007);
        chk("post_reset_err", 32'(wb_err), 32'd1);
        chk("post_reset_pend", 32'(pend_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
